// File: rtl/cu_sequencer.sv
// Multi-cycle control sequencer for the 16-bit stack CPU: FETCH/EXEC/WB/HALT FSM
// with stack-depth tracking. Define CU_CONDJUMP_EN for mask-based conditional jumps.
module cu_sequencer #(
  parameter int STACK_DEPTH = 16
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [0:17] i_instruction,
  input  logic [0:15] i_condVal,
  output logic        o_ipW,
  output logic        o_cond,
  output logic        o_TW,
  output logic        o_TIn,
  output logic        o_RW,
  output logic        o_RS,
  output logic        o_stkW,
  output logic        o_stkS,
  output logic [3:0]  o_spCtrl,
  output logic        o_carryW,
  output logic        o_instrType,
  output logic [5:0]  o_aluOP,
  output logic [1:0]  o_jSelCtrl,
  output logic        o_halted,
  output logic        o_fault
);
  localparam int DW = $clog2(STACK_DEPTH + 1);
  localparam logic [DW-1:0] FULL = DW'(STACK_DEPTH);

  typedef enum logic [1:0] {FETCH, EXEC, WB, HALT} state_t;

  state_t        state;
  logic [0:10]   ir;     // literal bits [11:17] go straight from ROM to T
  logic [DW-1:0] depth;
  logic          fault;

  logic unusedLit;
  assign unusedLit = ^i_instruction[11:17];

  logic [1:0] cls, dest;
  logic [3:0] stkOp;
  logic [2:0] mask;
  logic       isPush, isPop, isSpLoad, isHalt, aluToT, needsWb;
  assign cls      = ir[0:1];
  assign stkOp    = ir[2:5];
  assign mask     = ir[4:6];
  assign dest     = ir[8:9];
  assign isPush   = (cls == 2'b11) && (stkOp == 4'b0000);
  assign isPop    = (cls == 2'b11) && (stkOp == 4'b0001);
  assign isSpLoad = (cls == 2'b11) && (stkOp == 4'b0011);
  assign isHalt   = (cls == 2'b11) && (stkOp == 4'b1111);
  assign aluToT   = (cls == 2'b00) && (dest == 2'b01);
  assign needsWb  = isPush || isPop || aluToT;

  // Stack faults are caught on the raw word so the offending instruction never strobes.
  logic inPush, inPop, stackFault;
  assign inPush     = (i_instruction[0:1] == 2'b11) && (i_instruction[2:5] == 4'b0000);
  assign inPop      = (i_instruction[0:1] == 2'b11) && (i_instruction[2:5] == 4'b0001);
  assign stackFault = (inPush && depth == FULL) || (inPop && depth == '0);

  logic neg, zero, pos, taken;
  assign neg  = i_condVal[0];
  assign zero = (i_condVal == '0);
  assign pos  = !neg && !zero;
`ifdef CU_CONDJUMP_EN
  assign taken = |(mask & {neg, zero, pos});
`else
  logic unusedCond;
  assign unusedCond = neg ^ zero ^ pos;
  assign taken = |mask;
`endif

  // With o_jSelCtrl at 00 the datapath presents R on i_condVal.
  logic [DW:0]   rSlice;
  logic [DW-1:0] depthFromR;
  assign rSlice     = i_condVal[15-DW:15];
  assign depthFromR = (rSlice > (DW+1)'(STACK_DEPTH)) ? FULL : rSlice[DW-1:0];

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= FETCH;
      ir    <= '0;
      depth <= '0;
      fault <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          ir <= i_instruction[0:10];
          if (stackFault) begin
            state <= HALT;
            fault <= 1'b1;
          end else begin
            state <= EXEC;
          end
        end
        EXEC: begin
          if (isHalt)       state <= HALT;
          else if (needsWb) state <= WB;
          else              state <= FETCH;
          if (isPush)   depth <= depth + DW'(1);
          if (isPop)    depth <= depth - DW'(1);
          if (isSpLoad) depth <= depthFromR;
        end
        WB:      state <= FETCH;
        default: state <= HALT;
      endcase
    end
  end

  always_comb begin
    o_ipW       = 1'b0;
    o_cond      = 1'b0;
    o_TW        = 1'b0;
    o_TIn       = 1'b0;
    o_RW        = 1'b0;
    o_RS        = 1'b0;
    o_stkW      = 1'b0;
    o_stkS      = 1'b0;
    o_spCtrl    = 4'b0000;
    o_carryW    = 1'b0;
    o_instrType = 1'b0;
    o_aluOP     = 6'b000000;
    o_jSelCtrl  = 2'b00;
    o_halted    = (state == HALT);
    o_fault     = fault;
    case (state)
      EXEC: begin
        o_instrType = (cls != 2'b00);
        case (cls)
          2'b00: begin
            o_aluOP  = ir[2:7];
            o_RW     = !dest[1];
            o_carryW = ir[10];
            o_ipW    = !aluToT;
          end
          2'b01: begin
            o_TW  = 1'b1;
            o_TIn = 1'b1;
            o_ipW = 1'b1;
          end
          2'b10: begin
            o_ipW  = 1'b1;
            o_cond = taken;
`ifdef CU_CONDJUMP_EN
            o_jSelCtrl = ir[2:3];
`endif
          end
          default: begin
            case (stkOp)
              4'b0000: o_spCtrl[1] = 1'b1;
              4'b0001: begin
                o_stkS = 1'b1;
                o_TW   = 1'b1;
              end
              4'b0010: begin
                o_spCtrl[0] = 1'b1;
                o_TW        = 1'b1;
                o_ipW       = 1'b1;
              end
              4'b0011: begin
                o_RS        = 1'b1;
                o_spCtrl[3] = 1'b1;
                o_ipW       = 1'b1;
              end
              4'b1111: ;
              default: o_ipW = 1'b1;
            endcase
          end
        endcase
      end
      WB: begin
        o_instrType = (cls != 2'b00);
        o_ipW       = 1'b1;
        if (isPush) begin
          o_RS   = 1'b1;
          o_stkW = 1'b1;
        end else if (isPop) begin
          o_spCtrl[2] = 1'b1;
        end else begin
          o_RS = 1'b1;
          o_TW = 1'b1;
        end
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_cu_sequencer.sv
// Scoreboard bench for cu_sequencer: an instruction-level model queues the expected
// per-cycle control vectors, a negedge monitor pops and compares them.
module tb_cu_sequencer;
  localparam int SD = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [17:0] instr = '0;
  logic [15:0] cv = '0;
  logic        ipW, cond, tW, tIn, rW, rS, stkW, stkS, carryW, iType, halted, fault;
  logic [3:0]  spCtrl;
  logic [5:0]  aluOP;
  logic [1:0]  jSel;

  cu_sequencer #(.STACK_DEPTH(SD)) dut (
    .i_clock(clk), .i_reset(rst), .i_instruction(instr), .i_condVal(cv),
    .o_ipW(ipW), .o_cond(cond), .o_TW(tW), .o_TIn(tIn), .o_RW(rW), .o_RS(rS),
    .o_stkW(stkW), .o_stkS(stkS), .o_spCtrl(spCtrl), .o_carryW(carryW),
    .o_instrType(iType), .o_aluOP(aluOP), .o_jSelCtrl(jSel),
    .o_halted(halted), .o_fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ipW, cond, tW, tIn, rW, rS, stkW, stkS;
    logic [3:0] sp;
    logic       carryW, iType;
    logic [5:0] alu;
    logic [1:0] jsel;
    logic       halted, fault;
  } outs_t;

  outs_t expQ[$];
  int    tests = 0;
  int    fails = 0;
  int    mDepth = 0;
  bit    mHalt = 0;

  // Monitor: compare every cycle that has an expectation; bus-driver exclusivity always.
  always @(negedge clk) begin
    outs_t act, e;
    act = {ipW, cond, tW, tIn, rW, rS, stkW, stkS, spCtrl, carryW, iType, aluOP, jSel, halted, fault};
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      tests++;
      if (act !== e) begin
        fails++;
        $display("FAIL ctrl t=%0t got=%h want=%h", $time, act, e);
      end
    end
    tests++;
    if (!$onehot0({rS, stkS, spCtrl[0]})) begin
      fails++;
      $display("FAIL busDrivers t=%0t got RS/stkS/spDrv=%b want at most one", $time,
               {rS, stkS, spCtrl[0]});
    end
  end

  // Instruction-level reference: returns the number of cycles the instruction occupies.
  task automatic model(input logic [17:0] w, input logic [15:0] c, output int n);
    int cls, stk, op, dest, car, sel, msk;
    bit tk;
    outs_t z, e, b;
    cls  = int'(w) >> 16;
    stk  = (int'(w) >> 12) & 15;
    op   = (int'(w) >> 10) & 63;
    dest = (int'(w) >> 8) & 3;
    car  = (int'(w) >> 7) & 1;
    sel  = (int'(w) >> 14) & 3;
    msk  = (int'(w) >> 11) & 7;
    z = '0; e = '0; b = '0;
    expQ.push_back(z);
    n = 1;
    if (cls == 3 && ((stk == 0 && mDepth == SD) || (stk == 1 && mDepth == 0))) begin
      z.halted = 1'b1; z.fault = 1'b1;
      expQ.push_back(z); expQ.push_back(z);
      n += 2; mHalt = 1;
      return;
    end
    case (cls)
      0: begin
        e.alu = 6'(op); e.rW = (dest < 2); e.carryW = car[0]; e.ipW = (dest != 1);
        expQ.push_back(e); n++;
        if (dest == 1) begin
          b.rS = 1; b.tW = 1; b.ipW = 1;
          expQ.push_back(b); n++;
        end
      end
      1: begin
        e.iType = 1; e.tW = 1; e.tIn = 1; e.ipW = 1;
        expQ.push_back(e); n++;
      end
      2: begin
`ifdef CU_CONDJUMP_EN
        tk = ((msk & 4) != 0 && c >= 16'h8000) || ((msk & 2) != 0 && c == 0) ||
             ((msk & 1) != 0 && c != 0 && c < 16'h8000);
        e.jsel = 2'(sel);
`else
        tk = (msk != 0);
`endif
        e.iType = 1; e.ipW = 1; e.cond = tk;
        expQ.push_back(e); n++;
      end
      default: begin
        e.iType = 1; b.iType = 1;
        case (stk)
          0: begin
            e.sp = 4'b0010; b.rS = 1; b.stkW = 1; b.ipW = 1;
            expQ.push_back(e); expQ.push_back(b); n += 2; mDepth++;
          end
          1: begin
            e.stkS = 1; e.tW = 1; b.sp = 4'b0100; b.ipW = 1;
            expQ.push_back(e); expQ.push_back(b); n += 2; mDepth--;
          end
          2: begin
            e.sp = 4'b0001; e.tW = 1; e.ipW = 1;
            expQ.push_back(e); n++;
          end
          3: begin
            e.rS = 1; e.sp = 4'b1000; e.ipW = 1;
            expQ.push_back(e); n++;
            mDepth = (int'(c) % 64 > SD) ? SD : int'(c) % 64;
          end
          15: begin
            expQ.push_back(e);
            z.halted = 1;
            expQ.push_back(z); expQ.push_back(z);
            n += 3; mHalt = 1;
          end
          default: begin
            e.ipW = 1;
            expQ.push_back(e); n++;
          end
        endcase
      end
    endcase
  endtask

  // Called at posedge+1 with the DUT in FETCH; returns at posedge+1 after the instruction.
  task automatic issue(input logic [17:0] w, input logic [15:0] c);
    int n;
    instr = w; cv = c;
    model(w, c, n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    mDepth = 0; mHalt = 0;
  endtask

  localparam logic [17:0] PUSH = {2'b11, 4'b0000, 12'h000};
  localparam logic [17:0] POP  = {2'b11, 4'b0001, 12'h000};

  initial begin
    int n, r;
    logic [17:0] w;
    logic [15:0] c;
    repeat (2) @(posedge clk);
    #1 rst = 0;

    issue({2'b01, 16'h1234}, 16'h0);
    for (int i = 0; i < SD + 1; i++) issue(PUSH, 16'h0);
    doReset();
    issue(POP, 16'h0);
    doReset();
    issue({2'b10, 2'b01, 3'b010, 11'h0}, 16'h0000);
    issue({2'b10, 2'b10, 3'b010, 11'h0}, 16'h8000);
    issue({2'b10, 2'b11, 3'b100, 11'h0}, 16'h8000);
    issue({2'b10, 2'b00, 3'b000, 11'h0}, 16'h0005);
    issue({2'b00, 6'b001001, 2'b01, 1'b1, 7'h0}, 16'h0);
    issue({2'b11, 4'b0011, 12'h0}, 16'h0003);
    issue(POP, 16'h0);

    // Reset pulsed in the WB cycle of a PUSH.
    instr = PUSH; cv = '0;
    model(PUSH, cv, n);
    repeat (2) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1;
    rst = 0; mDepth = 0; mHalt = 0;
    issue(POP, 16'h0);
    doReset();

    for (int i = 0; i < 400; i++) begin
      w = {2'($urandom_range(0, 3)), 16'($urandom)};
      c = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      if (w[17:16] == 2'b11) begin
        r = $urandom_range(0, 9);
        case (r)
          0, 1, 2: w[15:12] = 4'b0000;
          3, 4:    w[15:12] = 4'b0001;
          5:       w[15:12] = 4'b0010;
          6: begin
            w[15:12] = 4'b0011;
            c = 16'($urandom_range(0, 40));
          end
          7:       w[15:12] = 4'($urandom);
          default: w[15:12] = ($urandom_range(0, 3) == 0) ? 4'b1111 : 4'b0100;
        endcase
      end
      issue(w, c);
      if (mHalt) doReset();
    end

    repeat (3) @(posedge clk);
    tests++;
    if (expQ.size() != 0) begin
      fails++;
      $display("FAIL drain got %0d pending want 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
